// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 slave serving a 2^ADDR_W x 8-bit register file
module spi_responder #(
  parameter int ADDR_W = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        reg0_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_d, ss_d, sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0] warm;
  logic armed;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte, tx_sh;
  logic [ADDR_W-1:0] addr;
  logic [7:0] regs [2**ADDR_W];
  logic last_bit;
  assign rx_byte = {rx_sh, mosi_q[SYNC_STAGES-1]};
  assign last_bit = sclk_rise && bit_cnt == 3'd7;
  assign spi_miso = tx_sh[7];
  assign busy = state != IDLE;
  assign reg0_out = regs[0];
  // Synchronize pins and register edge pulses; arming waits until the chain reflects a real high SS_n
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sclk_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d <= 1'b1;
      {sclk_rise, sclk_fall, ss_rise, ss_fall} <= '0;
      warm <= '0;
      armed <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      ss_q <= {ss_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      ss_d <= ss_q[SYNC_STAGES-1];
      sclk_rise <= sclk_q[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_q[SYNC_STAGES-1] & sclk_d;
      ss_rise <= ss_q[SYNC_STAGES-1] & ~ss_d;
      ss_fall <= ~ss_q[SYNC_STAGES-1] & ss_d;
      warm <= warm + 8'(warm != 8'(SYNC_STAGES + 1));
      armed <= armed | (warm == 8'(SYNC_STAGES + 1) && ss_d);
    end
  end
  // State register
  always_ff @(posedge clk_in) state <= !rst ? IDLE : state_nx;
  // Next state: SS_n rising always wins, command byte picks the data direction
  always_comb begin
    state_nx = ss_rise ? IDLE :
               (state == IDLE && ss_fall && armed) ? CMD :
               (state == CMD && last_bit) ? (rx_byte[7] ? WDATA : RDATA) : state;
  end
  // Bit shifting, address tracking, register writes and MISO shifting
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      bit_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      addr <= '0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      spi_miso_oe <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      spi_miso_oe <= busy;
      if (state == IDLE || ss_rise) bit_cnt <= '0;
      else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh <= rx_byte[6:0];
        if (bit_cnt == 3'd7) begin
          addr <= state == CMD ? rx_byte[ADDR_W-1:0] : addr + 1'b1;
          if (state == WDATA) begin
            regs[addr] <= rx_byte;
            wr_stb <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_byte;
          end
        end
      end
      tx_sh <= (state != RDATA || ss_rise) ? 8'h00 :
               !sclk_fall ? tx_sh :
               bit_cnt == 3'd0 ? regs[addr] : {tx_sh[6:0], 1'b0};
    end
  end
endmodule
